candidate_matcher: RTL and testbench
====================================

Name: candidate_matcher

Overview:
- Downstream stage of the brute-force candidate generator.
- Accepts one 4-digit base-36 candidate per cycle over a valid/ready handshake, converts each digit to ASCII and compares the 4-char string against a loaded target password.
- Reports the first match (sticky), or exhaustion when the generator's last candidate of its range fails to match.
- Counts how many candidates were compared.

Parameters:
- NUM_CHARS, 4: characters per candidate.
- DIGIT_W, 6: bits per base-36 digit.
- CNT_W, 24: width of checked_count (≥ 21 covers all 36^4 candidates).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- target_load  input  1  pulse: latch target_password and restart search
- target_password  input  8*NUM_CHARS  ASCII target; char 0 in MSBs [31:24]
- cand_valid  input  1  generator presents a candidate
- cand_ready  output  1  block accepts candidate this cycle
- cand_digits  input  DIGIT_W*NUM_CHARS  digit 0 in MSBs [23:18]
- cand_last  input  1  qualifies cand_valid: final candidate of the range
- match_found  output  1  sticky: match detected
- match_password  output  8*NUM_CHARS  ASCII of the matching candidate
- done  output  1  search finished (found or exhausted)
- checked_count  output  CNT_W  candidates compared since last target_load

Behaviour:
- Clock and reset: clk; synchronous active-high rst.
- Reset values: state=IDLE, cand_ready=0, match_found=0, match_password=0, done=0, checked_count=0, pipeline valids=0, target register=0.
- Digit mapping:
  - 0..25 → 'a'..'z' (8'h61+d).
  - 26..35 → '0'..'9' (8'h30+d-26).
  - 36..63 → illegal: the candidate never matches but is still counted.
- States:
  - IDLE: no target loaded. cand_ready=0.
  - SEARCH: cand_ready = !target_load.
  - FOUND: match_found=1, done=1, cand_ready=0.
  - EXHAUSTED: done=1, match_found=0, cand_ready=0.
- Transitions:
  - target_load in any state → SEARCH. Latches the target, clears checked_count, match_found, match_password, done and all pipeline valids.
  - SEARCH → FOUND when the stage-2 valid entry compares equal.
  - SEARCH → EXHAUSTED when the stage-2 entry is valid, flagged last, and does not match.
  - FOUND and EXHAUSTED are held until target_load or rst.
- Pipeline (2 stages):
  - Accept (cand_valid & cand_ready) at cycle N → stage 1 registers ASCII + last flag + illegal flag at edge N+1.
  - Stage 2 compares and updates outputs at edge N+2. match_found is first visible in cycle N+2.
- checked_count:
  - Increments once per stage-2 valid entry, including the matching one.
  - Saturates at all-ones and does not wrap.
- On match:
  - match_password gets the stage-2 ASCII.
  - Any candidate in stage 1 is discarded and not counted.
  - cand_ready drops combinationally from the FOUND state onward.
- Simultaneous target_load and cand_valid: no handshake (cand_ready=0). The candidate is not consumed, and the generator holds it.
- Match and cand_last on the same entry: FOUND takes priority over EXHAUSTED.
- rst mid-search: everything returns to reset values within one cycle, and the target must be reloaded.
- cand_digits and cand_last are only sampled on handshake. The generator must hold them stable while valid & !ready.

Decomposition:
- Package password_cracker_pkg:
  - Constants CHARSET_SIZE=36, NUM_CHARS, DIGIT_W, ASCII_A=8'h61, ASCII_0=8'h30.
  - State enum {IDLE, SEARCH, FOUND, EXHAUSTED}.
  - Function digit_to_ascii.
- Sub-module base36_to_ascii: combinational converter for one digit. Outputs an 8-bit char and an illegal flag. Instantiated NUM_CHARS times ahead of the stage-1 register.

Test Plan:
- Conversion sweep:
  - Stimulus: target "a0z9"; feed the single candidate {0,26,25,35}.
  - Response: match_found=1 and done=1 exactly 2 cycles after accept; match_password=32'h61307A39; checked_count=1.
- Streaming match:
  - Stimulus: target "ab12" = {0,1,27,28}; stream candidates {0,1,27,20}..{0,1,27,35} back-to-back, cand_valid held high.
  - Response: match on the 9th candidate; checked_count=9; cand_ready low from the cycle match_found rises; later candidates not consumed.
- Exhaustion:
  - Stimulus: target "zzzz"; 5 non-matching candidates, the last with cand_last=1.
  - Response: done=1, match_found=0, checked_count=5, cand_ready=0.
- Illegal digit:
  - Stimulus: target "aaaa"; candidate {0,0,0,36} then {0,0,0,0}.
  - Response: first is counted, no match; second matches; checked_count=2.
- Backpressure and reload:
  - Stimulus: assert target_load while cand_valid=1 mid-search.
  - Response: cand_ready=0 that cycle; next cycle counters are 0 and state is SEARCH; the held candidate is accepted then.
- Reset mid-pipeline:
  - Stimulus: rst=1 one cycle after an accept of a matching candidate.
  - Response: match_found never rises; all outputs 0; cand_ready=0 until the next target_load.

Source files
------------

// File: rtl/password_cracker_pkg.sv
// Shared constants, state encoding and digit conversion
// for the brute-force password cracker datapath.
package password_cracker_pkg;

  localparam int CHARSET_SIZE = 36;
  localparam int NUM_CHARS    = 4;
  localparam int DIGIT_W      = 6;

  localparam logic [7:0] ASCII_A = 8'h61;
  localparam logic [7:0] ASCII_0 = 8'h30;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    FOUND,
    EXHAUSTED
  } state_t;

  // Illegal digits map to 8'h00, which never equals a printable target char.
  function automatic logic [7:0] digit_to_ascii(
    input logic [DIGIT_W-1:0] d
  );
    logic [7:0] dx;
    dx = 8'(d);
    if (dx < 8'd26)
      return ASCII_A + dx;
    else if (dx < 8'(CHARSET_SIZE))
      return ASCII_0 + dx - 8'd26;
    else
      return 8'h00;
  endfunction

endpackage

// File: rtl/candidate_matcher_base36_to_ascii.sv
// Combinational base-36 digit to ASCII converter,
// one instance per candidate character.
module base36_to_ascii
  import password_cracker_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [7:0]         ascii,
  output logic               illegal
);

  assign illegal = (digit >= DIGIT_W'(CHARSET_SIZE));
  assign ascii   = digit_to_ascii(digit);

endmodule

// File: rtl/candidate_matcher.sv
// Two-stage candidate matcher: convert digits to ASCII,
// then compare against the loaded target password.
module candidate_matcher
  import password_cracker_pkg::*;
#(
  parameter int NUM_CHARS = 4,
  parameter int DIGIT_W   = 6,
  parameter int CNT_W     = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     target_load,
  input  logic [8*NUM_CHARS-1:0]   target_password,
  input  logic                     cand_valid,
  output logic                     cand_ready,
  input  logic [DIGIT_W*NUM_CHARS-1:0] cand_digits,
  input  logic                     cand_last,
  output logic                     match_found,
  output logic [8*NUM_CHARS-1:0]   match_password,
  output logic                     done,
  output logic [CNT_W-1:0]         checked_count
);

  state_t state;

  logic [8*NUM_CHARS-1:0] target;
  logic [8*NUM_CHARS-1:0] conv_ascii;
  logic [NUM_CHARS-1:0]   conv_illegal;

  logic                   s1_valid;
  logic [8*NUM_CHARS-1:0] s1_ascii;
  logic                   s1_last;
  logic                   s1_illegal;

  logic accept;
  logic s2_match;

  for (genvar i = 0; i < NUM_CHARS; i++) begin : g_conv
    base36_to_ascii u_conv (
      .digit   (cand_digits[DIGIT_W*(NUM_CHARS-i)-1 -: DIGIT_W]),
      .ascii   (conv_ascii[8*(NUM_CHARS-i)-1 -: 8]),
      .illegal (conv_illegal[i])
    );
  end

  assign cand_ready = (state == SEARCH) && !target_load;
  assign accept     = cand_valid && cand_ready;
  assign s2_match   = s1_valid && !s1_illegal && (s1_ascii == target);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      target         <= '0;
      s1_valid       <= 1'b0;
      s1_ascii       <= '0;
      s1_last        <= 1'b0;
      s1_illegal     <= 1'b0;
      match_found    <= 1'b0;
      match_password <= '0;
      done           <= 1'b0;
      checked_count  <= '0;
    end else if (target_load) begin
      state          <= SEARCH;
      target         <= target_password;
      s1_valid       <= 1'b0;
      match_found    <= 1'b0;
      match_password <= '0;
      done           <= 1'b0;
      checked_count  <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_ascii   <= conv_ascii;
        s1_last    <= cand_last;
        s1_illegal <= |conv_illegal;
      end
      unique case (state)
        SEARCH: begin
          if (s1_valid) begin
            if (checked_count != '1)
              checked_count <= checked_count + 1'b1;
            // A match drops whatever was accepted behind it.
            if (s2_match) begin
              state          <= FOUND;
              match_found    <= 1'b1;
              match_password <= s1_ascii;
              done           <= 1'b1;
              s1_valid       <= 1'b0;
            end else if (s1_last) begin
              state    <= EXHAUSTED;
              done     <= 1'b1;
              s1_valid <= 1'b0;
            end
          end
        end
        IDLE, FOUND, EXHAUSTED: begin
          s1_valid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_candidate_matcher.sv
// Randomized self-checking bench for candidate_matcher
// against a string-level reference model.
module tb_candidate_matcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        target_load;
  logic [31:0] target_password;
  logic        cand_valid;
  logic        cand_ready;
  logic [23:0] cand_digits;
  logic        cand_last;
  logic        match_found;
  logic [31:0] match_password;
  logic        done;
  logic [23:0] checked_count;

  int n_checks = 0;
  int n_err    = 0;

  logic [23:0] cq[$];
  bit          lq[$];

  candidate_matcher #(
    .NUM_CHARS (4),
    .DIGIT_W   (6),
    .CNT_W     (24)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .target_load     (target_load),
    .target_password (target_password),
    .cand_valid      (cand_valid),
    .cand_ready      (cand_ready),
    .cand_digits     (cand_digits),
    .cand_last       (cand_last),
    .match_found     (match_found),
    .match_password  (match_password),
    .done            (done),
    .checked_count   (checked_count)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] dg4(input int a, b, c, d);
    return {6'(a), 6'(b), 6'(c), 6'(d)};
  endfunction

  // Reference: string of a candidate, and whether every digit is legal.
  function automatic bit cand_str(
    input  logic [23:0] dg,
    output logic [31:0] s
  );
    string cs;
    int    d;
    bit    ok;
    cs = "abcdefghijklmnopqrstuvwxyz0123456789";
    ok = 1'b1;
    s  = '0;
    for (int i = 0; i < 4; i++) begin
      d = int'(dg[23-6*i -: 6]);
      if (d >= 36) begin
        ok = 1'b0;
      end else begin
        s[31-8*i -: 8] = cs[d];
      end
    end
    return ok;
  endfunction

  task automatic load_target(input logic [31:0] tgt);
    @(negedge clk);
    target_load     = 1'b1;
    target_password = tgt;
    cand_valid      = 1'b0;
    @(negedge clk);
    target_load = 1'b0;
  endtask

  // Streams cq/lq into the DUT, then checks the outcome against the model.
  task automatic run_search(
    input string       tag,
    input logic [31:0] tgt,
    input bit          gaps
  );
    logic [23:0] acc[$];
    bit          accl[$];
    int          acc_edge[$];
    logic [31:0] s;
    int idx, edge_n, rise, k, lastk, budget;
    bit hs, holding, ok;
    idx = 0; edge_n = 0; rise = -1; holding = 1'b0;
    load_target(tgt);
    check({tag, "_cnt0"}, checked_count, 0);
    for (budget = 0; budget < 300 && !done; budget++) begin
      if (idx < cq.size() &&
          (holding || !gaps || $urandom_range(0, 3) != 0)) begin
        cand_valid  = 1'b1;
        cand_digits = cq[idx];
        cand_last   = lq[idx];
      end else begin
        cand_valid = 1'b0;
      end
      #1;
      hs      = cand_valid && cand_ready;
      holding = cand_valid && !cand_ready;
      @(posedge clk);
      edge_n++;
      if (hs) begin
        acc.push_back(cq[idx]);
        accl.push_back(lq[idx]);
        acc_edge.push_back(edge_n);
        idx++;
      end
      @(negedge clk);
      if (match_found && rise < 0) begin
        rise = edge_n;
        check({tag, "_rdy_at_match"}, cand_ready, 0);
      end
    end
    cand_valid = 1'b0;
    check({tag, "_done"}, done, 1);
    k = -1; lastk = -1;
    foreach (acc[i]) begin
      if (k < 0 && lastk < 0) begin
        ok = cand_str(acc[i], s);
        if (ok && s == tgt) k = i;
        else if (accl[i]) lastk = i;
      end
    end
    if (k >= 0) begin
      check({tag, "_match"}, match_found, 1);
      check({tag, "_pw"}, match_password, tgt);
      check({tag, "_cnt"}, checked_count, k + 1);
      check({tag, "_lat"}, rise, acc_edge[k] + 1);
      check({tag, "_no_extra"}, acc.size() <= k + 2, 1);
    end else begin
      check({tag, "_nomatch"}, match_found, 0);
      check({tag, "_pw0"}, match_password, 0);
      check({tag, "_cnt"}, checked_count, lastk + 1);
    end
    check({tag, "_rdy_end"}, cand_ready, 0);
  endtask

  initial begin
    logic [31:0] tgt;
    logic [23:0] td;
    int n, pos, dd[4];
    rst = 1'b1; target_load = 1'b0; target_password = '0;
    cand_valid = 1'b1; cand_digits = '0; cand_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_match", match_found, 0);
    check("rst_done", done, 0);
    check("rst_cnt", checked_count, 0);
    check("rst_pw", match_password, 0);
    check("rst_rdy", cand_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rdy", cand_ready, 0);
    cand_valid = 1'b0;

    // conversion sweep
    cq = {dg4(0, 26, 25, 35)}; lq = {1'b0};
    run_search("sweep", 32'h61307A39, 1'b0);
    check("sweep_pw_const", match_password, 32'h61307A39);

    // streaming match on 9th candidate
    cq.delete(); lq.delete();
    for (int i = 0; i < 16; i++) begin
      cq.push_back(dg4(0, 1, 27, 20 + i));
      lq.push_back(1'b0);
    end
    run_search("stream", 32'h61623132, 1'b0);
    check("stream_cnt9", checked_count, 9);

    // exhaustion
    cq.delete(); lq.delete();
    for (int i = 0; i < 5; i++) begin
      cq.push_back(dg4(0, 0, 0, i));
      lq.push_back(i == 4);
    end
    run_search("exh", 32'h7A7A7A7A, 1'b0);
    check("exh_cnt5", checked_count, 5);

    // illegal digit
    cq = {dg4(0, 0, 0, 36), dg4(0, 0, 0, 0)}; lq = {1'b0, 1'b1};
    run_search("illegal", 32'h61616161, 1'b0);
    check("illegal_cnt2", checked_count, 2);

    // reload while a candidate is presented
    load_target(32'h61626364);
    cand_valid = 1'b1; cand_digits = dg4(0, 0, 0, 0); cand_last = 1'b0;
    @(negedge clk);
    cand_digits = dg4(1, 1, 1, 1);
    target_load = 1'b1; target_password = 32'h62626262;
    #1 check("reload_rdy0", cand_ready, 0);
    @(negedge clk);
    target_load = 1'b0;
    check("reload_cnt0", checked_count, 0);
    check("reload_done0", done, 0);
    #1 check("reload_rdy1", cand_ready, 1);
    @(negedge clk);
    cand_valid = 1'b0;
    @(negedge clk);
    check("reload_match", match_found, 1);
    check("reload_cnt1", checked_count, 1);

    // reset one cycle after accepting a matching candidate
    load_target(32'h61626364);
    cand_valid = 1'b1; cand_digits = dg4(0, 1, 2, 3); cand_last = 1'b0;
    #1 check("rstp_rdy", cand_ready, 1);
    @(negedge clk);
    cand_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cand_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rstp_match", match_found, 0);
      check("rstp_outs", {done, checked_count, match_password}, 0);
      check("rstp_rdy", cand_ready, 0);
      @(negedge clk);
    end
    cand_valid = 1'b0;

    // randomized searches
    for (int it = 0; it < 25; it++) begin
      for (int j = 0; j < 4; j++) dd[j] = $urandom_range(0, 35);
      td = dg4(dd[0], dd[1], dd[2], dd[3]);
      void'(cand_str(td, tgt));
      n   = $urandom_range(2, 10);
      pos = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      cq.delete(); lq.delete();
      for (int i = 0; i < n; i++) begin
        if (i == pos) begin
          cq.push_back(td);
        end else begin
          for (int j = 0; j < 4; j++)
            dd[j] = ($urandom_range(0, 7) == 0) ?
                    $urandom_range(36, 63) : $urandom_range(0, 35);
          cq.push_back(dg4(dd[0], dd[1], dd[2], dd[3]));
        end
        lq.push_back(i == n - 1);
      end
      run_search($sformatf("rnd%0d", it), tgt, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
